// File: rtl/mouse_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_packetizer_if
//  Description : Byte-stream handshake between the mouse packetizer and the
//                downstream FIFO writer.
//                  tx_data  - packet byte
//                  tx_valid - tx_data holds a byte
//                  tx_ready - sink accepts the byte this cycle
//                A byte moves on every clock edge with tx_valid & tx_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mouse_packetizer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/mouse_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_packetizer
//  Description : Turns absolute touch events (press/release/move/scroll) into
//                relative PS/2 mouse packets and streams the bytes out over a
//                valid/ready interface. Events arriving while a packet is in
//                flight are coalesced into a one-deep pending slot.
//  Ports       : clock, reset_n (async, active low)
//                touch_h/touch_v   - absolute coordinates (10 bit)
//                is_press/is_release/is_move/is_scroll - gesture flags
//                send_mouse_enable - one-cycle event strobe
//                tx                - byte stream (mouse_packetizer_if.master)
//                busy              - high whenever not IDLE
//                drop_count        - saturating count of lost click transitions
//  Options     : MOUSE_PACKETIZER_SCROLL_EN - 4-byte wheel packets; when
//                undefined, packets are 3 bytes and is_scroll acts as a move.
//  Revision    : 1.0 - initial release
// ============================================================================
module mouse_packetizer #(
    parameter int GAIN_SHIFT = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [9:0]                 touch_h,
    input  logic [9:0]                 touch_v,
    input  logic                       is_press,
    input  logic                       is_release,
    input  logic                       is_move,
    input  logic                       is_scroll,
    input  logic                       send_mouse_enable,
    mouse_packetizer_if.master         tx,
    output logic                       busy,
    output logic [7:0]                 drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUILD = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_SEND2 = 3'd4,
        ST_SEND3 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_MOVE    = 2'd2,
        EV_SCROLL  = 2'd3
    } event_t;

    state_t      r_state;
    logic        r_btn_left;
    logic        r_btn_prev;     // button state before the working event
    logic        r_have_ref;
    logic [9:0]  r_ref_h, r_ref_v;
    logic        r_pend_valid;
    event_t      r_pend_kind;
    logic [9:0]  r_pend_h, r_pend_v;
    logic        r_pend_btn;
    event_t      r_work_kind;
    logic [9:0]  r_work_h, r_work_v;
    logic [7:0]  r_byte1, r_byte2;
`ifdef MOUSE_PACKETIZER_SCROLL_EN
    logic [7:0]  r_byte3;
`endif
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_drop_count;

    function automatic logic apply_btn(input event_t kind, input logic base);
        case (kind)
            EV_PRESS:   apply_btn = 1'b1;
            EV_RELEASE: apply_btn = 1'b0;
            default:    apply_btn = base;
        endcase
    endfunction

    // Returns {overflow, value[8:0]} after gain and saturation to -256..255.
    function automatic logic [9:0] sat9(input logic [10:0] raw);
        logic signed [13:0] v;
        v = $signed({{3{raw[10]}}, raw}) <<< GAIN_SHIFT;
        if (v > 14'sd255)
            sat9 = {1'b1, 9'h0FF};
        else if (v < -14'sd256)
            sat9 = {1'b1, 9'h100};
        else
            sat9 = {1'b0, v[8:0]};
    endfunction

    // Incoming event decode; a single strobe carries one event, the first
    // asserted flag in press/release/move/scroll order wins.
    logic   w_any;
    event_t w_in_kind;
    always_comb begin
        w_any = is_press | is_release | is_move | is_scroll;
        if (is_press)
            w_in_kind = EV_PRESS;
        else if (is_release)
            w_in_kind = EV_RELEASE;
`ifdef MOUSE_PACKETIZER_SCROLL_EN
        else if (is_move)
            w_in_kind = EV_MOVE;
        else
            w_in_kind = EV_SCROLL;
`else
        else
            w_in_kind = EV_MOVE;
`endif
    end

    // Pending-slot button tracking: a click lost when a new event undoes a
    // still-unsent button change held in the slot.
    logic w_slot_base, w_slot_btn, w_reverse;
    always_comb begin
        w_slot_base = r_pend_valid ? r_pend_btn : r_btn_left;
        w_slot_btn  = apply_btn(w_in_kind, w_slot_base);
        w_reverse   = r_pend_valid && (r_pend_btn != r_btn_left) &&
                      (w_slot_btn != r_pend_btn);
    end

    // Packet build from the working event.
    logic [10:0] w_raw_dx, w_raw_dy;
    logic        w_no_ref_move, w_use_delta, w_btn_new, w_skip;
    logic [9:0]  w_sx, w_sy;
    logic [3:0]  w_wheel;
    logic [7:0]  w_byte0;
    always_comb begin
        w_raw_dx      = {1'b0, r_work_h} - {1'b0, r_ref_h};
        w_raw_dy      = {1'b0, r_ref_v} - {1'b0, r_work_v};
        w_no_ref_move = (r_work_kind == EV_MOVE) && !r_have_ref;
        w_use_delta   = (r_work_kind == EV_MOVE) && r_have_ref;
        w_sx          = w_use_delta ? sat9(w_raw_dx) : 10'd0;
        w_sy          = w_use_delta ? sat9(w_raw_dy) : 10'd0;
        w_wheel       = 4'd0;
`ifdef MOUSE_PACKETIZER_SCROLL_EN
        if (r_work_kind == EV_SCROLL) begin
            if ($signed(w_raw_dy) > 11'sd31)
                w_wheel = 4'h7;
            else if ($signed(w_raw_dy) < -11'sd32)
                w_wheel = 4'h8;
            else
                w_wheel = w_raw_dy[5:2];  // arithmetic >>> 2, range already fits
        end
`endif
        // A move with no reference point acts like a press.
        w_btn_new = r_btn_left | w_no_ref_move;
        w_skip    = (w_sx == 10'd0) && (w_sy == 10'd0) &&
                    (w_btn_new == r_btn_prev) && (w_wheel == 4'd0);
        w_byte0   = {w_sy[9], w_sx[9], w_sy[8], w_sx[8], 3'b100, w_btn_new};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_btn_left   <= 1'b0;
            r_btn_prev   <= 1'b0;
            r_have_ref   <= 1'b0;
            r_ref_h      <= 10'd0;
            r_ref_v      <= 10'd0;
            r_pend_valid <= 1'b0;
            r_pend_kind  <= EV_PRESS;
            r_pend_h     <= 10'd0;
            r_pend_v     <= 10'd0;
            r_pend_btn   <= 1'b0;
            r_work_kind  <= EV_PRESS;
            r_work_h     <= 10'd0;
            r_work_v     <= 10'd0;
            r_byte1      <= 8'd0;
            r_byte2      <= 8'd0;
`ifdef MOUSE_PACKETIZER_SCROLL_EN
            r_byte3      <= 8'd0;
`endif
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            // Any flagged strobe outside IDLE lands in the pending slot.
            if (r_state != ST_IDLE && send_mouse_enable && w_any) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= w_in_kind;
                r_pend_h     <= touch_h;
                r_pend_v     <= touch_v;
                r_pend_btn   <= w_slot_btn;
                if (w_reverse && r_drop_count != 8'hFF)
                    r_drop_count <= r_drop_count + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (send_mouse_enable && w_any) begin
                        r_work_kind <= w_in_kind;
                        r_work_h    <= touch_h;
                        r_work_v    <= touch_v;
                        r_btn_prev  <= r_btn_left;
                        r_btn_left  <= apply_btn(w_in_kind, r_btn_left);
                        r_state     <= ST_BUILD;
                    end else if (r_pend_valid) begin
                        r_work_kind  <= r_pend_kind;
                        r_work_h     <= r_pend_h;
                        r_work_v     <= r_pend_v;
                        r_btn_prev   <= r_btn_left;
                        r_btn_left   <= r_pend_btn;
                        r_pend_valid <= 1'b0;
                        r_state      <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    r_btn_left <= w_btn_new;
                    if (r_work_kind == EV_PRESS || w_no_ref_move)
                        r_have_ref <= 1'b1;
                    else if (r_work_kind == EV_RELEASE)
                        r_have_ref <= 1'b0;
                    if (w_skip) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ref_h    <= r_work_h;
                        r_ref_v    <= r_work_v;
                        r_tx_data  <= w_byte0;
                        r_tx_valid <= 1'b1;
                        r_byte1    <= w_sx[7:0];
                        r_byte2    <= w_sy[7:0];
`ifdef MOUSE_PACKETIZER_SCROLL_EN
                        r_byte3    <= {{4{w_wheel[3]}}, w_wheel};
`endif
                        r_state    <= ST_SEND0;
                    end
                end
                ST_SEND0: if (r_tx_valid && tx.tx_ready) begin
                    r_tx_data <= r_byte1;
                    r_state   <= ST_SEND1;
                end
                ST_SEND1: if (r_tx_valid && tx.tx_ready) begin
                    r_tx_data <= r_byte2;
                    r_state   <= ST_SEND2;
                end
                ST_SEND2: if (r_tx_valid && tx.tx_ready) begin
`ifdef MOUSE_PACKETIZER_SCROLL_EN
                    r_tx_data  <= r_byte3;
                    r_state    <= ST_SEND3;
`else
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
`endif
                end
                ST_SEND3: if (r_tx_valid && tx.tx_ready) begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = (r_state != ST_IDLE);
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire
